fc_act_loader: RTL
==================

FC_ACT_LOADER -- requirements
Module: fc_act_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8: activation width in bits.
REQ-002 SHALL have parameter IN, default 128: activations per frame, matching the fully-connected layer fan-in.
REQ-003 SHALL have parameter ZW, default 22 (WIDTH*2+6): width of the layer result.
REQ-004 SHALL have parameter SETTLE, default 2 (minimum 1): cycles the combinational layer gets to settle.
REQ-005 SHALL have parameter SHIFT, default 8: right-shift applied when requantizing the result.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 s_valid  input  1  upstream activation beat valid.
REQ-009 s_ready  output  1  block accepts a beat.
REQ-010 s_data  input  WIDTH  unsigned activation.
REQ-011 s_last  input  1  marks the final beat of a frame.
REQ-012 x_vec  output  IN x WIDTH  parallel activation array driven into the layer's x input.
REQ-013 z_in  input  ZW  ReLU-ed layer result read back from the layer's z output.
REQ-014 m_valid  output  1  requantized result valid.
REQ-015 m_ready  input  1  downstream accepts the result.
REQ-016 m_data  output  WIDTH  requantized activation.
REQ-017 err_len  output  1  one-cycle pulse on a frame-length error.

Function
REQ-018 FSM states SHALL be LOAD, WAIT and OUT.
- s_ready = (state==LOAD).
- m_valid = (state==OUT).
REQ-019 Beat handshake in LOAD SHALL be s_valid & s_ready.
- On a handshake, buffer[idx] <= s_data.
- idx SHALL be a 7-bit counter for IN=128, $clog2(IN) bits in general.
REQ-020 A handshake with idx < IN-1 and s_last=0 SHALL increment idx.
REQ-021 A handshake with idx < IN-1 and s_last=1 SHALL be an early end:
- err_len pulses for 1 cycle;
- idx <= 0;
- state stays LOAD;
- the partial frame is discarded, with no m_valid for it.
REQ-022 A handshake with idx == IN-1 SHALL complete the frame regardless of s_last:
- idx <= 0;
- state <= WAIT;
- settle counter <= SETTLE-1.
- If s_last=0 on this beat, err_len SHALL pulse for 1 cycle (late/missing last), and the frame is still processed.
REQ-023 x_vec SHALL equal the buffer contents at all times and SHALL be stable in WAIT and OUT.
REQ-024 In WAIT the counter SHALL decrement each cycle. In the cycle it equals 0:
- the block captures z_in;
- state <= OUT.
- If the last beat is accepted at edge T, m_valid SHALL first be high after edge T+SETTLE.
REQ-025 Requantization SHALL be performed on the captured z_in:
- If z_in[ZW-1]=1, the result SHALL be 0 (negative clamp, defensive).
- Otherwise q = z_in >> SHIFT (logical shift).
- m_data = (q > 2^WIDTH-1) ? 2^WIDTH-1 : q[WIDTH-1:0].
REQ-026 In OUT, m_data SHALL be held stable until m_valid & m_ready.
- On that handshake, state <= LOAD, so s_ready is high in the next cycle.
- No new beat SHALL be accepted in the same cycle as the output handshake.
REQ-027 s_valid with s_ready low (WAIT/OUT) SHALL be ignored and SHALL cause no state change and no error.
REQ-028 err_len SHALL be registered and SHALL never be high for 2 consecutive cycles unless errors occur on consecutive beats.

Reset
REQ-029 On rst_n low, regardless of clock or state, the block SHALL immediately:
- enter LOAD;
- set idx=0 and the settle counter to 0;
- clear every buffer entry (and hence x_vec) to 0;
- set m_data=0, m_valid=0 and err_len=0.
REQ-030 s_ready SHALL be 1 during and after reset, since the state is LOAD.
REQ-031 A reset asserted mid-frame or mid-WAIT/OUT SHALL discard all progress, and the first beat after release SHALL be written to buffer[0].

Verification
REQ-032 Reset release: after rst_n rises -> s_ready=1, m_valid=0, err_len=0, all x_vec entries 0.
REQ-033 Nominal frame: 128 beats s_data=i, s_last on beat 127, z_in=3200, last beat accepted at edge T:
- x_vec[i]=i;
- m_valid rises after edge T+2;
- m_data=12.
REQ-034 Saturation and clamp:
- z_in=65536 -> m_data=255;
- z_in=0x200000 (MSB set) -> m_data=0;
- z_in=255 -> m_data=0.
REQ-035 Early end: s_last on beat 5 -> err_len high exactly 1 cycle, no m_valid; a following full 128-beat frame writes from buffer[0] and produces correct m_data.
REQ-036 Backpressure: m_ready held low 10 cycles in OUT -> m_data and x_vec stable, s_ready=0, s_valid ignored; m_ready high -> s_ready=1 on the next cycle.
REQ-037 Reset mid-frame: assert rst_n low after 60 beats -> x_vec all 0 at once; next 128-beat frame completes normally with correct m_data.

Source files
------------

// File: rtl/fc_act_loader.sv
// Streams WIDTH-bit activations into a parallel IN-entry array for a combinational FC layer,
// waits SETTLE cycles, then requantizes the layer's ReLU output and hands it downstream.
module fc_act_loader #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned IN     = 128,
    parameter int unsigned ZW     = 22,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned SHIFT  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_last,
    output logic [IN*WIDTH-1:0]   x_vec,
    input  logic [ZW-1:0]         z_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  err_len
);

    localparam int unsigned IW = (IN > 1) ? $clog2(IN) : 1;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(IN - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);
    localparam logic [ZW-1:0] SAT_MAX  = ZW'((64'd1 << WIDTH) - 64'd1);

    typedef enum logic [1:0] {LOAD, WAIT, OUT} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IN*WIDTH-1:0]   buf_q, buf_d;
    logic [WIDTH-1:0]      m_data_q, m_data_d;
    logic                  err_q, err_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic [ZW-1:0]         z_shift;
    logic [WIDTH-1:0]      q_c;

    // Requantize: clamp negatives to zero, shift down, saturate to WIDTH bits.
    always_comb begin
        z_shift = z_in >> SHIFT;
        if (z_in[ZW-1]) begin
            q_c = '0;
        end else if (z_shift > SAT_MAX) begin
            q_c = '1;
        end else begin
            q_c = z_shift[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        m_data_d = m_data_q;
        err_d    = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    buf_d[int'(idx_q)*WIDTH +: WIDTH] = s_data;
                    if (idx_q == IDX_LAST) begin
                        // A full frame is processed even when s_last is missing; only flagged.
                        idx_d   = '0;
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                        err_d   = ~s_last;
                    end else if (s_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    m_data_d = q_c;
                    state_d  = OUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        s_ready_d = (state_d == LOAD);
        m_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err_len = err_q;
    assign x_vec   = buf_q;

endmodule
